// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// cpu_sequencer : multi-cycle fetch/decode/exec/mem/wb sequencer for the CPU.
// Option: define SEQ_PERF_CNT_EN to add the retired_cnt output. Rev 1.0
// ============================================================================
module cpu_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [3:0]         opcode,
    output logic [2:0]         rf_raddr1,
    output logic [2:0]         rf_raddr2,
    output logic [2:0]         rf_waddr,
    output logic               rf_we,
    input  logic               cu_reg_write,
    input  logic               cu_mem_read,
    input  logic               cu_mem_write,
    input  logic               cu_branch,
    output logic               alu_start,
    input  logic               alu_done,
    input  logic               branch_taken,
    output logic               dmem_rd,
    output logic               dmem_wr,
    input  logic               dmem_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               fault
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]        retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [7:0]        WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_ONE    = 1;

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] ir;
    logic               alu_busy;
    logic               mem_rd_q;
    logic               mem_wr_q;
    logic               reg_wr_q;
    logic               taken_q;
    logic [7:0]         wait_cnt;
    logic               retire;
    logic               take;
    logic [ADDR_W-1:0]  imm_sext;
    logic [ADDR_W-1:0]  pc_next;

    // Control flags are captured at alu_done so MEM/WB depend only on state and registers.
    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (ir[15:12] == 4'hF) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (alu_done) begin
                    if (cu_mem_read && cu_mem_write)      state_nxt = S_FAULT;
                    else if (cu_mem_read || cu_mem_write) state_nxt = S_MEM;
                    else if (cu_reg_write)                state_nxt = S_WB;
                    else                                  retire    = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (reg_wr_q) state_nxt = S_WB;
                    else          retire    = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB:     retire = 1'b1;
            default:  state_nxt = state;
        endcase
        if (retire) state_nxt = S_FETCH;
    end

    // Retiring straight out of EXEC uses the live branch result; later stages use the latched one.
    always_comb begin
        take     = (state == S_EXEC) ? (cu_branch & branch_taken) : taken_q;
        imm_sext = {{(ADDR_W-6){ir[5]}}, ir[5:0]};
        pc_next  = take ? (pc + imm_sext) : (pc + PC_ONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir       <= '0;
            alu_busy <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            reg_wr_q <= 1'b0;
            taken_q  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            alu_busy <= (state == S_EXEC) && (state_nxt == S_EXEC);
            if (state == S_FETCH && imem_ack) ir <= imem_data;
            if (state == S_EXEC && alu_done) begin
                mem_rd_q <= cu_mem_read;
                mem_wr_q <= cu_mem_write;
                reg_wr_q <= cu_reg_write;
                taken_q  <= cu_branch & branch_taken;
            end
            if (state != S_MEM)
                wait_cnt <= '0;
            else if (!dmem_ready && wait_cnt != WAIT_LAST)
                wait_cnt <= wait_cnt + 8'd1;
            if (retire) pc <= pc_next;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            retired_cnt <= '0;
        else if (retire && retired_cnt != 16'hFFFF)
            retired_cnt <= retired_cnt + 16'd1;
    end
`endif

    always_comb begin
        imem_req  = (state == S_FETCH);
        imem_addr = pc;
        opcode    = ir[15:12];
        rf_waddr  = ir[11:9];
        rf_raddr1 = ir[8:6];
        rf_raddr2 = ir[5:3];
        rf_we     = (state == S_WB);
        alu_start = (state == S_EXEC) && !alu_busy;
        dmem_rd   = (state == S_MEM) && mem_rd_q;
        dmem_wr   = (state == S_MEM) && mem_wr_q;
        halted    = (state == S_HALT);
        fault     = (state == S_FAULT);
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cpu_sequencer : scoreboard bench with imem/ALU/dmem/ControlUnit models.
// Honours SEQ_PERF_CNT_EN for retired_cnt. Rev 1.0
// ============================================================================
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  opcode;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic        rf_we;
    logic        cu_reg_write, cu_mem_read, cu_mem_write, cu_branch;
    logic        alu_start, alu_done, branch_taken;
    logic        dmem_rd, dmem_wr, dmem_ready;
    logic [7:0]  pc;
    logic        halted, fault;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] imem [256];
    int          imem_lat = 1;
    int          alu_lat = 1;
    int          dmem_lat = 1;
    logic        tb_taken = 1'b0;
    logic [7:0]  exp_fetch [$];
    logic [8:0]  exp_wb [$];      // {waddr, raddr1, raddr2}

    always #5 clk = ~clk;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .opcode(opcode), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .cu_reg_write(cu_reg_write), .cu_mem_read(cu_mem_read),
        .cu_mem_write(cu_mem_write), .cu_branch(cu_branch),
        .alu_start(alu_start), .alu_done(alu_done), .branch_taken(branch_taken),
        .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_ready(dmem_ready),
        .pc(pc), .halted(halted), .fault(fault)
`ifdef SEQ_PERF_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    // ControlUnit model: 0-7 ALU, 8 LOAD, 9 STORE, A BRANCH, B illegal rd+wr, C NOP, F HALT.
    assign cu_reg_write = (opcode <= 4'h8);
    assign cu_mem_read  = (opcode == 4'h8) || (opcode == 4'hB);
    assign cu_mem_write = (opcode == 4'h9) || (opcode == 4'hB);
    assign cu_branch    = (opcode == 4'hA);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        run   = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        fill_imem();
    endtask

    task automatic wait_end(input string tag, input logic [1:0] want);
        for (int i = 0; i < 400 && !halted && !fault; i++) @(negedge clk);
        check_val(tag, {halted, fault}, want);
    endtask

    task automatic end_test(input string tag, input int exp_ret);
        check_val({tag, "_fetch_q_left"}, exp_fetch.size(), 0);
        check_val({tag, "_wb_q_left"}, exp_wb.size(), 0);
        exp_fetch.delete();
        exp_wb.delete();
`ifdef SEQ_PERF_CNT_EN
        check_val({tag, "_retired_cnt"}, retired_cnt, exp_ret);
`endif
    endtask

    // Instruction memory: ack after imem_lat wait cycles; random noise on ack/data when idle.
    initial begin : imem_model
        int cnt;
        cnt = 0; imem_ack = 1'b0; imem_data = '0;
        forever begin
            @(negedge clk);
            if (reset && imem_req) begin
                imem_ack = 1'b0;
                if (cnt >= imem_lat) begin
                    imem_ack  = 1'b1;
                    imem_data = imem[imem_addr];
                    cnt = 0;
                end else cnt++;
            end else begin
                cnt = 0;
                imem_ack  = 1'($urandom_range(0, 1));
                imem_data = 16'($urandom);
            end
        end
    end

    initial begin : alu_model
        int cnt;
        bit pend;
        cnt = 0; pend = 1'b0; alu_done = 1'b0; branch_taken = 1'b0;
        forever begin
            @(negedge clk);
            alu_done     = 1'b0;
            branch_taken = 1'($urandom_range(0, 1));
            if (!reset) pend = 1'b0;
            else begin
                if (alu_start) begin pend = 1'b1; cnt = alu_lat; end
                if (pend) begin
                    if (cnt == 0) begin
                        alu_done = 1'b1; branch_taken = tb_taken; pend = 1'b0;
                    end else cnt--;
                end
            end
        end
    end

    initial begin : dmem_model
        int cnt;
        cnt = 0; dmem_ready = 1'b0;
        forever begin
            @(negedge clk);
            dmem_ready = 1'b0;
            if (reset && (dmem_rd || dmem_wr)) begin
                if (cnt >= dmem_lat) begin dmem_ready = 1'b1; cnt = 0; end
                else cnt++;
            end else cnt = 0;
        end
    end

    initial begin : monitor
        logic       prev_req, prev_we, prev_start;
        logic [7:0] cur_addr;
        logic [8:0] e;
        prev_req = 1'b0; prev_we = 1'b0; prev_start = 1'b0; cur_addr = '0;
        forever begin
            @(negedge clk);
            if (imem_req && !prev_req) begin
                if (exp_fetch.size() == 0)
                    check_val("fetch_unexpected", imem_addr, 32'hFFFF_FFFF);
                else begin
                    cur_addr = exp_fetch.pop_front();
                    check_val("fetch_addr", imem_addr, cur_addr);
                end
            end else if (imem_req) begin
                check_val("fetch_addr_hold", imem_addr, cur_addr);
            end
            if (alu_start) check_val("alu_start_pulse", prev_start, 0);
            if (rf_we) begin
                check_val("rf_we_pulse", prev_we, 0);
                if (exp_wb.size() == 0)
                    check_val("wb_unexpected", rf_waddr, 32'hFFFF_FFFF);
                else begin
                    e = exp_wb.pop_front();
                    check_val("wb_waddr", rf_waddr, e[8:6]);
                    check_val("wb_raddr1", rf_raddr1, e[5:3]);
                    check_val("wb_raddr2", rf_raddr2, e[2:0]);
                end
            end
            prev_req = imem_req; prev_we = rf_we; prev_start = alu_start;
        end
    end

    initial begin : main
        int n;
        fill_imem();
        repeat (2) @(negedge clk);
        check_val("rst_pc", pc, 0);
        check_val("rst_req", imem_req, 0);
        check_val("rst_opcode", opcode, 0);
        check_val("rst_strobes", {halted, fault, rf_we, alu_start, dmem_rd, dmem_wr}, 0);
`ifdef SEQ_PERF_CNT_EN
        check_val("rst_retired_cnt", retired_cnt, 0);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_no_run", imem_req, 0);

        // ALU op with write-back, then HALT; run ignored while halted
        imem[0] = 16'h1234; imem_lat = 3; alu_lat = 2;
        exp_fetch = '{8'd0, 8'd1};
        exp_wb.push_back({3'd1, 3'd0, 3'd6});
        run = 1'b1;
        wait_end("t1_halted", 2'b10);
        check_val("t1_pc", pc, 1);
        n = 0;
        repeat (20) begin @(negedge clk); if (imem_req) n++; end
        check_val("t1_halt_no_fetch", n, 0);
        check_val("t1_halt_sticky", halted, 1);
        end_test("t1", 1);

        // Taken branches: 0 -> +8 -> 8, 8 -> -4 -> 4
        do_reset();
        check_val("halt_cleared", halted, 0);
        imem_lat = 1; alu_lat = 1; tb_taken = 1'b1;
        imem[0] = 16'hA008; imem[8] = 16'hA03C;
        exp_fetch = '{8'd0, 8'd8, 8'd4};
        run = 1'b1;
        wait_end("t2a_halted", 2'b10);
        check_val("t2a_pc", pc, 4);
        end_test("t2a", 2);

        // Not-taken branch at 8 falls through to 9; ALU done in the start cycle
        do_reset();
        alu_lat = 0; tb_taken = 1'b0;
        for (int i = 0; i < 8; i++) imem[i] = 16'hC000;
        imem[8] = 16'hA03C;
        for (int i = 0; i < 10; i++) exp_fetch.push_back(8'(i));
        run = 1'b1;
        wait_end("t2b_halted", 2'b10);
        check_val("t2b_pc", pc, 9);
        end_test("t2b", 9);

        // Branch 0 -> 0xFF, write-back op at 0xFF wraps pc to 0
        do_reset();
        alu_lat = 1; tb_taken = 1'b1;
        imem[0] = 16'hA03F; imem[255] = 16'h1234;
        exp_fetch = '{8'd0, 8'hFF, 8'd0};
        exp_wb.push_back({3'd1, 3'd0, 3'd6});
        run = 1'b1;
        for (int i = 0; i < 100 && !(imem_req && imem_addr == 8'hFF); i++) @(negedge clk);
        imem[0] = 16'hF000;
        wait_end("t3_halted", 2'b10);
        check_val("t3_pc_wrap", pc, 0);
        end_test("t3", 2);

        // Load never acknowledged: fault after exactly 15 MEM cycles
        do_reset();
        dmem_lat = 1000;
        imem[0] = 16'h8A00;
        exp_fetch = '{8'd0};
        run = 1'b1;
        for (int i = 0; i < 100 && !dmem_rd; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 50 && dmem_rd; i++) begin n++; @(negedge clk); end
        check_val("t4_mem_cycles", n, 15);
        check_val("t4_fault", fault, 1);
        check_val("t4_dmem_rd_drop", dmem_rd, 0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req || dmem_rd || dmem_wr || rf_we || alu_start) n++;
        end
        check_val("t4_quiet", n, 0);
        check_val("t4_fault_sticky", fault, 1);
        end_test("t4", 0);

        // Load acknowledged in the 5th MEM cycle: write-back, no fault
        do_reset();
        check_val("fault_cleared", fault, 0);
        dmem_lat = 4;
        imem[0] = 16'h8A00;
        exp_fetch = '{8'd0, 8'd1};
        exp_wb.push_back({3'd5, 3'd0, 3'd0});
        run = 1'b1;
        for (int i = 0; i < 100 && !dmem_rd; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 50 && dmem_rd; i++) begin n++; @(negedge clk); end
        check_val("t4b_mem_cycles", n, 5);
        wait_end("t4b_halted", 2'b10);
        check_val("t4b_pc", pc, 1);
        end_test("t4b", 1);

        // Reset asserted between clock edges during a store
        do_reset();
        dmem_lat = 1000;
        imem[0] = 16'hC000; imem[1] = 16'h9000;
        exp_fetch = '{8'd0, 8'd1};
        run = 1'b1;
        for (int i = 0; i < 100 && !dmem_wr; i++) @(negedge clk);
        @(negedge clk);
        check_val("t6_pre_wr", dmem_wr, 1);
        check_val("t6_pre_pc", pc, 1);
        #2 reset = 1'b0; run = 1'b0;
        #1;
        check_val("t6_async_wr", dmem_wr, 0);
        check_val("t6_async_pc", pc, 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (10) begin @(negedge clk); if (imem_req) n++; end
        check_val("t6_idle_until_run", n, 0);
        end_test("t6", 0);

        // Both memory flags set at alu_done: fault without any memory strobe
        do_reset();
        imem[0] = 16'hB000;
        exp_fetch = '{8'd0};
        run = 1'b1;
        wait_end("t7_fault", 2'b01);
        check_val("t7_no_strobe", {dmem_rd, dmem_wr}, 0);
        end_test("t7", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
